// File: rtl/trap_sequencer.sv
// Machine-mode trap and MRET sequencer: walks the CSR file through the
// mepc/mcause/mtval/mstatus updates, then issues a one-cycle PC redirect.
module trap_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        excValid,
  input  logic [3:0]  excCause,
  input  logic [31:0] excPC,
  input  logic [31:0] excTval,
  input  logic        irqExt,
  input  logic [31:0] irqPC,
  input  logic        mretValid,
  input  logic        pipeWen,
  input  logic [11:0] pipeWAddr,
  input  logic [31:0] pipeWd,
  output logic        busy,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  output logic [11:0] csrAddr,
  output logic        csrRen,
  output logic [11:0] csrWAddr,
  output logic        csrWen,
  output logic [31:0] csrWd,
  input  logic [31:0] csrRd
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [31:0] IRQ_CAUSE   = 32'h8000_000B;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    T_EPC    = 4'd1,
    T_CAUSE  = 4'd2,
    T_TVAL   = 4'd3,
    T_STATUS = 4'd4,
    M_EPC    = 4'd5,
    M_STAT   = 4'd6,
    M_LATCH  = 4'd7,
    M_WRITE  = 4'd8,
    REDIRECT = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic        is_irq_q, is_irq_d;
  logic        is_mret_q, is_mret_d;
  logic        mie_q, mie_d;
  logic        meie_q, meie_d;

  logic        irq_take;
  logic [31:0] trap_mstatus;
  logic [31:0] mret_mstatus;
  logic [31:0] trap_target;
  logic [31:0] mret_target;
  logic        unused_pipe_bits;

  assign unused_pipe_bits = ^{pipeWd[31:12], pipeWd[10:4], pipeWd[2:0]};

  // Shadow enables are the values before any pipeline write landing this cycle.
  assign irq_take = irqExt && mie_q && meie_q;

  assign trap_mstatus = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3],
                         mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
  assign mret_mstatus = {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7],
                         mstatus_q[2:0]};

  assign trap_target = {mtvec_q[31:2], 2'b00} +
                       (((mtvec_q[1:0] == 2'b01) && is_irq_q) ? 32'h0000_002C : 32'h0);
  assign mret_target = {epc_q[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
      mie_q     <= 1'b0;
      meie_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      is_irq_q  <= is_irq_d;
      is_mret_q <= is_mret_d;
      mie_q     <= mie_d;
      meie_q    <= meie_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    is_irq_d  = is_irq_q;
    is_mret_d = is_mret_q;
    mie_d     = mie_q;
    meie_d    = meie_q;

    case (state_q)
      IDLE: begin
        if (pipeWen && (pipeWAddr == CSR_MSTATUS)) mie_d  = pipeWd[3];
        if (pipeWen && (pipeWAddr == CSR_MIE))     meie_d = pipeWd[11];
        if (excValid) begin
          epc_d     = excPC;
          cause_d   = {28'b0, excCause};
          tval_d    = excTval;
          is_irq_d  = 1'b0;
          is_mret_d = 1'b0;
          state_d   = T_EPC;
        end else if (mretValid) begin
          is_irq_d  = 1'b0;
          is_mret_d = 1'b1;
          state_d   = M_EPC;
        end else if (irq_take) begin
          epc_d     = irqPC;
          cause_d   = IRQ_CAUSE;
          tval_d    = 32'h0;
          is_irq_d  = 1'b1;
          is_mret_d = 1'b0;
          state_d   = T_EPC;
        end
      end
      T_EPC:    state_d = T_CAUSE;
      T_CAUSE: begin
        mstatus_d = csrRd;
        state_d   = T_TVAL;
      end
      T_TVAL: begin
        mtvec_d = csrRd;
        state_d = T_STATUS;
      end
      T_STATUS: begin
        mie_d   = 1'b0;
        state_d = REDIRECT;
      end
      M_EPC:    state_d = M_STAT;
      M_STAT: begin
        epc_d   = csrRd;
        state_d = M_LATCH;
      end
      M_LATCH: begin
        mstatus_d = csrRd;
        state_d   = M_WRITE;
      end
      M_WRITE: begin
        mie_d   = mstatus_q[7];
        state_d = REDIRECT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    csrRen        = (state_q != IDLE);
    redirectValid = 1'b0;
    redirectPC    = 32'h0;
    csrAddr       = 12'h0;
    csrWAddr      = 12'h0;
    csrWen        = 1'b0;
    csrWd         = 32'h0;

    case (state_q)
      T_EPC: begin
        csrAddr  = CSR_MSTATUS;
        csrWen   = 1'b1;
        csrWAddr = CSR_MEPC;
        csrWd    = epc_q;
      end
      T_CAUSE: begin
        csrAddr  = CSR_MTVEC;
        csrWen   = 1'b1;
        csrWAddr = CSR_MCAUSE;
        csrWd    = cause_q;
      end
      T_TVAL: begin
        csrAddr  = CSR_MTVAL;
        csrWen   = 1'b1;
        csrWAddr = CSR_MTVAL;
        csrWd    = tval_q;
      end
      T_STATUS: begin
        csrAddr  = CSR_MSTATUS;
        csrWen   = 1'b1;
        csrWAddr = CSR_MSTATUS;
        csrWd    = trap_mstatus;
      end
      M_EPC:   csrAddr = CSR_MEPC;
      M_STAT:  csrAddr = CSR_MSTATUS;
      M_LATCH: csrAddr = CSR_MSTATUS;
      M_WRITE: begin
        csrAddr  = CSR_MSTATUS;
        csrWen   = 1'b1;
        csrWAddr = CSR_MSTATUS;
        csrWd    = mret_mstatus;
      end
      REDIRECT: begin
        redirectValid = 1'b1;
        redirectPC    = is_mret_q ? mret_target : trap_target;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: a CSR file model answers reads, the
// stimulus queues expected CSR writes and redirects, a monitor checks them.
`timescale 1ns/1ps
module tb_trap_sequencer;

  logic        clock;
  logic        reset;
  logic        excValid;
  logic [3:0]  excCause;
  logic [31:0] excPC;
  logic [31:0] excTval;
  logic        irqExt;
  logic [31:0] irqPC;
  logic        mretValid;
  logic        pipeWen;
  logic [11:0] pipeWAddr;
  logic [31:0] pipeWd;
  logic        busy;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic [11:0] csrAddr;
  logic        csrRen;
  logic [11:0] csrWAddr;
  logic        csrWen;
  logic [31:0] csrWd;
  logic [31:0] csrRd;

  trap_sequencer dut (
    .clock(clock), .reset(reset),
    .excValid(excValid), .excCause(excCause), .excPC(excPC), .excTval(excTval),
    .irqExt(irqExt), .irqPC(irqPC), .mretValid(mretValid),
    .pipeWen(pipeWen), .pipeWAddr(pipeWAddr), .pipeWd(pipeWd),
    .busy(busy), .redirectValid(redirectValid), .redirectPC(redirectPC),
    .csrAddr(csrAddr), .csrRen(csrRen), .csrWAddr(csrWAddr), .csrWen(csrWen),
    .csrWd(csrWd), .csrRd(csrRd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // CSR file model with registered read and a bench-only preload port.
  logic [31:0] mem [0:4095];
  logic        bd_wen;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;
  always @(posedge clock) begin
    if (csrWen)  mem[csrWAddr]  <= csrWd;
    if (pipeWen) mem[pipeWAddr] <= pipeWd;
    if (bd_wen)  mem[bd_addr]   <= bd_data;
    csrRd <= mem[csrAddr];
  end

  typedef struct { logic [11:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [31:0] pc; int cyc; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  always @(negedge clock) begin
    if (reset && csrWen) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", csrWAddr, csrWd, cyc);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (csrWAddr !== e.addr || csrWd !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL csr_write got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   csrWAddr, csrWd, cyc, e.addr, e.data, e.cyc);
        end else begin
          $display("write addr=%h data=%h cyc=%0d ok", csrWAddr, csrWd, cyc);
        end
      end
    end
    if (reset && redirectValid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect pc=%h cyc=%0d", redirectPC, cyc);
      end else begin
        rd_t r;
        r = rq.pop_front();
        if (redirectPC !== r.pc || cyc != r.cyc) begin
          errors++;
          $display("FAIL redirect got pc=%h cyc=%0d want pc=%h cyc=%0d",
                   redirectPC, cyc, r.pc, r.cyc);
        end else begin
          $display("redirect pc=%h cyc=%0d ok", redirectPC, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},          {31'b0, busy}, 32'h0);
    chk({tag, "_redirectValid"}, {31'b0, redirectValid}, 32'h0);
    chk({tag, "_redirectPC"},    redirectPC, 32'h0);
    chk({tag, "_csrAddr"},       {20'b0, csrAddr}, 32'h0);
    chk({tag, "_csrRen"},        {31'b0, csrRen}, 32'h0);
    chk({tag, "_csrWAddr"},      {20'b0, csrWAddr}, 32'h0);
    chk({tag, "_csrWen"},        {31'b0, csrWen}, 32'h0);
    chk({tag, "_csrWd"},         csrWd, 32'h0);
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input int c);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = c;
    wq.push_back(w);
  endtask

  task automatic push_rd(input logic [31:0] pc, input int c);
    rd_t r;
    r.pc = pc; r.cyc = c;
    rq.push_back(r);
  endtask

  task automatic push_trap(input int b, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] mst,
                           input logic [31:0] tgt);
    push_wr(12'h341, epc, b + 1);
    push_wr(12'h342, cause, b + 2);
    push_wr(12'h343, tval, b + 3);
    push_wr(12'h300, mst, b + 4);
    push_rd(tgt, b + 5);
  endtask

  task automatic backdoor(input logic [11:0] a, input logic [31:0] d);
    bd_wen = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_wen = 1'b0;
  endtask

  task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
    pipeWen = 1'b1; pipeWAddr = a; pipeWd = d;
    step();
    pipeWen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; excValid = 1'b0; excCause = 4'h0; excPC = 32'h0; excTval = 32'h0;
    irqExt = 1'b0; irqPC = 32'h0; mretValid = 1'b0;
    pipeWen = 1'b0; pipeWAddr = 12'h0; pipeWd = 32'h0;
    bd_wen = 1'b0; bd_addr = 12'h0; bd_data = 32'h0;

    repeat (3) step();
    chk_outputs_zero("reset");
    backdoor(12'h300, 32'h0000_0008);
    backdoor(12'h305, 32'h0000_0200);

    // Exception accepted on the very first edge after release.
    reset = 1'b1;
    excValid = 1'b1; excCause = 4'd2; excPC = 32'h100; excTval = 32'hDEAD;
    push_trap(cyc, 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h200);
    step();
    excValid = 1'b0;
    chk("exc_busy", {31'b0, busy}, 32'h1);
    repeat (7) step();

    // Vectored external interrupt.
    pipe_write(12'h305, 32'h0000_0201);
    pipe_write(12'h300, 32'h0000_0008);
    pipe_write(12'h304, 32'h0000_0800);
    irqExt = 1'b1; irqPC = 32'h40;
    push_trap(cyc, 32'h40, 32'h8000_000B, 32'h0, 32'h1880, 32'h22C);
    step();
    irqExt = 1'b0;
    repeat (7) step();

    // Pipe write clearing MIE in the same cycle still sees the old shadow.
    pipe_write(12'h300, 32'h0000_0008);
    pipeWen = 1'b1; pipeWAddr = 12'h300; pipeWd = 32'h0;
    irqExt = 1'b1; irqPC = 32'h80;
    push_trap(cyc, 32'h80, 32'h8000_000B, 32'h0, 32'h1800, 32'h22C);
    step();
    pipeWen = 1'b0; irqExt = 1'b0;
    repeat (7) step();

    // Masked interrupt: MIE shadow is 0 after the trap, MEIE still 1.
    irqExt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("masked_busy_%0d", i), {31'b0, busy}, 32'h0);
    end
    irqExt = 1'b0;

    // MRET.
    backdoor(12'h341, 32'h0000_0107);
    backdoor(12'h300, 32'h0000_1880);
    mretValid = 1'b1;
    push_wr(12'h300, 32'h1888, cyc + 4);
    push_rd(32'h104, cyc + 5);
    step();
    mretValid = 1'b0;
    repeat (7) step();

    // Priority: all three requests together, then pulses while busy.
    excValid = 1'b1; excCause = 4'd5; excPC = 32'h300; excTval = 32'h1234;
    mretValid = 1'b1; irqExt = 1'b1; irqPC = 32'h999;
    push_trap(cyc, 32'h300, 32'h5, 32'h1234, 32'h1880, 32'h200);
    step();
    excValid = 1'b0; mretValid = 1'b0;
    step();
    excValid = 1'b1; mretValid = 1'b1; excPC = 32'h777;
    step();
    excValid = 1'b0; mretValid = 1'b0;
    step();
    step();
    irqExt = 1'b0;
    repeat (8) step();
    chk("prio_idle_busy", {31'b0, busy}, 32'h0);

    // Reset while in T_TVAL.
    excValid = 1'b1; excCause = 4'd7; excPC = 32'h500; excTval = 32'hBEEF;
    push_wr(12'h341, 32'h500, cyc + 1);
    push_wr(12'h342, 32'h7, cyc + 2);
    step();
    excValid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (3) step();
    reset = 1'b1;
    repeat (8) step();
    chk("post_reset_busy", {31'b0, busy}, 32'h0);
    chk("mtval_untouched", mem[12'h343], 32'h1234);

    chk("writes_drained", wq.size(), 32'h0);
    chk("redirects_drained", rq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; 0 = reset.
REQ-003 SHALL have ports: excValid  in  1  single-cycle synchronous exception request.
REQ-004 SHALL have ports: excCause  in  4  exception code; excPC  in  32  faulting PC; excTval  in  32  trap value.
REQ-005 SHALL have ports: irqExt  in  1  level external interrupt; irqPC  in  32  PC of next unexecuted instruction.
REQ-006 SHALL have ports: mretValid  in  1  single-cycle MRET request.
REQ-007 SHALL have ports: pipeWen  in  1, pipeWAddr  in  12, pipeWd  in  32  pipeline CSR write snoop.
REQ-008 SHALL have ports: busy  out  1  owns CSR port, pipeline stalls; redirectValid  out  1  one-cycle pulse; redirectPC  out  32.
REQ-009 SHALL have ports: csrAddr  out  12, csrRen  out  1, csrWAddr  out  12, csrWen  out  1, csrWd  out  32, csrRd  in  32, the CSR file port; csrRd is valid one cycle after csrAddr.

Function
REQ-010 SHALL be FSM, states: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, M_EPC, M_STAT, M_LATCH, M_WRITE, REDIRECT.
REQ-011 busy SHALL equal (state != IDLE); requests while busy are ignored.
REQ-012 IDLE priority SHALL be: excValid > mretValid > interrupt; the accepted request is sampled in the cycle it is high.
REQ-013 Interrupt SHALL be taken only when irqExt=1, shadow MIE=1 and shadow MEIE=1.
REQ-014 On accept SHALL latch: exception: epc=excPC, cause={28'b0,excCause}, tval=excTval; interrupt: epc=irqPC, cause=0x8000000B, tval=0; isIrq flag.
REQ-015 Trap path SHALL be IDLE->T_EPC->T_CAUSE->T_TVAL->T_STATUS->REDIRECT->IDLE, one cycle each.
REQ-016 T_EPC SHALL write mepc (0x341)=epc and read 0x300.
REQ-017 T_CAUSE SHALL write mcause (0x342)=cause, read 0x305, and latch csrRd as mstatus.
REQ-018 T_TVAL SHALL write mtval (0x343)=tval and latch csrRd as mtvec.
REQ-019 T_STATUS SHALL write mstatus (0x300) = latched value with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(12:11)=2'b11.
REQ-020 Trap target SHALL be {mtvec[31:2],2'b00}, plus 0x2C when mtvec[1:0]=01 and isIrq; 32-bit wrap-around, no overflow detection.
REQ-021 MRET path SHALL be IDLE->M_EPC->M_STAT->M_LATCH->M_WRITE->REDIRECT->IDLE.
REQ-022 M_EPC SHALL read 0x341; M_STAT SHALL read 0x300 and latch mepc; M_LATCH SHALL latch mstatus.
REQ-023 M_WRITE SHALL write mstatus with MIE=MPIE, MPIE=1, other bits unchanged.
REQ-024 MRET target SHALL be {mepc[31:2],2'b00}.
REQ-025 REDIRECT SHALL assert redirectValid=1 with redirectPC for exactly one cycle; redirect occurs 5 cycles after accept on both paths.
REQ-026 csrRen SHALL be 1 in every non-IDLE state; csrWen SHALL be 1 only in write states; csrWen=0 and csrRen=0 in IDLE.
REQ-027 Shadows MIE and MEIE SHALL update from pipeWen writes to 0x300 (bit3) and 0x304 (bit11) in IDLE, and from own mstatus writes.
REQ-028 Simultaneous pipeWen to 0x300 and interrupt check SHALL use the pre-write shadow in that cycle.

Reset
REQ-029 reset=0 SHALL immediately force IDLE and clear all outputs (busy, redirectValid, redirectPC, csrAddr, csrRen, csrWAddr, csrWen, csrWd), shadows, and latches to 0, including mid-sequence.
REQ-030 After release, the first accept SHALL be possible on the first rising edge with reset=1.

Verification
REQ-031 Exception: excValid, excCause=2, excPC=0x100, excTval=0xDEAD, mtvec=0x200 -> writes mepc=0x100, mcause=2, mtval=0xDEAD, mstatus MIE=0; redirectPC=0x200 at cycle 5.
REQ-032 Vectored interrupt: mtvec=0x201, MIE=MEIE=1 via pipe writes, irqExt=1, irqPC=0x40 -> mcause=0x8000000B, mepc=0x40, redirectPC=0x22C.
REQ-033 Masked: irqExt=1, MIE=0 -> busy stays 0, no CSR writes for 20 cycles.
REQ-034 MRET: mepc=0x107, mstatus=0x1880 -> mstatus write 0x1888, redirectPC=0x104 at cycle 5.
REQ-035 Priority: excValid, mretValid and enabled irqExt in the same cycle -> exception path only; a pulse while busy is ignored.
REQ-036 Reset in T_TVAL -> outputs 0 at once; no further CSR writes; IDLE after release.
